pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges the ID-stage load-use/branch stall request with data-memory wait, instruction-fetch wait, taken-branch redirect and a multi-cycle mult/div unit. It drives one coherent set of keep/zero/flush controls to the PC and to the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also owns the mult/div busy sequencer and a stall-cycle performance counter.

---
 rtl/pipeline_stall_controller_pkg.sv | 72 +++++++
 rtl/pipeline_stall_controller_muldiv.sv | 69 ++++++
 rtl/pipeline_stall_controller.sv | 72 +++++++
 tb/tb_pipeline_stall_controller.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer: mult/div
// state encoding, stall cause priority and the per-register control bundle.
package pipeline_stall_controller_pkg;

  localparam int R_WIDTH            = 32;
  localparam int DEFAULT_MULDIV_LAT = 32;
  localparam int DEFAULT_CNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_DMEM,
    CAUSE_ID_STALL,
    CAUSE_BRANCH,
    CAUSE_IMEM
  } stall_cause_t;

  typedef struct packed {
    logic pc_keep;
    logic if_id_keep;
    logic if_id_flush;
    logic id_ex_keep;
    logic id_ex_zero;
    logic ex_mem_keep;
    logic mem_wb_zero;
  } pipe_ctrl_t;

  // Highest-priority condition wins; lower ones are ignored for that cycle.
  function automatic stall_cause_t resolve_cause(input logic dmem_wait,
                                                 input logic id_stall,
                                                 input logic branch_taken,
                                                 input logic imem_wait);
    if (dmem_wait)         return CAUSE_DMEM;
    else if (id_stall)     return CAUSE_ID_STALL;
    else if (branch_taken) return CAUSE_BRANCH;
    else if (imem_wait)    return CAUSE_IMEM;
    else                   return CAUSE_NONE;
  endfunction

  function automatic pipe_ctrl_t decode_ctrl(input stall_cause_t cause);
    pipe_ctrl_t c;
    c = '0;
    case (cause)
      CAUSE_DMEM: begin
        c.pc_keep     = 1'b1;
        c.if_id_keep  = 1'b1;
        c.id_ex_keep  = 1'b1;
        c.ex_mem_keep = 1'b1;
        c.mem_wb_zero = 1'b1;
      end
      CAUSE_ID_STALL: begin
        c.pc_keep    = 1'b1;
        c.if_id_keep = 1'b1;
        c.id_ex_zero = 1'b1;
      end
      // Redirect: PC loads the target while the fetched slot is squashed.
      CAUSE_BRANCH: c.if_id_flush = 1'b1;
      CAUSE_IMEM: begin
        c.pc_keep     = 1'b1;
        c.if_id_flush = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_muldiv.sv
// Mult/div busy sequencer: IDLE -> BUSY for MULDIV_LAT cycles -> DONE pulse.
// A start is accepted only when the EX/MEM register is not being held.
module muldiv_sequencer
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MULDIV_LAT = DEFAULT_MULDIV_LAT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start,
  input  logic hold,
  output logic busy,
  output logic done
);

  localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MULDIV_LAT - 1);

  muldiv_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  assign accept = start & ~hold;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value; the combinational block below uses blocking ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: next-state and counter get their hold values first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          state_d = MD_BUSY;
          cnt_d   = LOAD_VAL;
        end
      end
      MD_BUSY: begin
        // Counter keeps running during a data-memory freeze.
        if (cnt_q == '0) state_d = MD_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      MD_DONE: begin
        if (accept) begin
          state_d = MD_BUSY;
          cnt_d   = LOAD_VAL;
        end else begin
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy = (state_q == MD_BUSY) & ~rst_i;
  assign done = (state_q == MD_DONE) & ~rst_i;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: prioritised
// keep/zero/flush controls, mult/div busy tracking and a stall-cycle counter.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MULDIV_LAT = DEFAULT_MULDIV_LAT,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 id_stall_req_i,
  input  logic                 branch_taken_i,
  input  logic                 hilo_use_i,
  input  logic                 muldiv_start_i,
  input  logic                 imem_ready_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_ready_i,
  output logic                 pc_keep_o,
  output logic                 if_id_keep_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_keep_o,
  output logic                 id_ex_zero_o,
  output logic                 ex_mem_keep_o,
  output logic                 mem_wb_zero_o,
  output logic                 muldiv_busy_o,
  output logic                 muldiv_done_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o
);

  logic         dmem_wait, imem_wait, id_stall;
  stall_cause_t cause;
  pipe_ctrl_t   ctrl;

  assign dmem_wait = dmem_req_i & ~dmem_ready_i;
  assign imem_wait = ~imem_ready_i;
  assign id_stall  = id_stall_req_i | (hilo_use_i & muldiv_busy_o);

  assign cause = resolve_cause(dmem_wait, id_stall, branch_taken_i, imem_wait);
  assign ctrl  = rst_i ? '0 : decode_ctrl(cause);

  assign pc_keep_o     = ctrl.pc_keep;
  assign if_id_keep_o  = ctrl.if_id_keep;
  assign if_id_flush_o = ctrl.if_id_flush;
  assign id_ex_keep_o  = ctrl.id_ex_keep;
  assign id_ex_zero_o  = ctrl.id_ex_zero;
  assign ex_mem_keep_o = ctrl.ex_mem_keep;
  assign mem_wb_zero_o = ctrl.mem_wb_zero;

  // A mult/div entering EX while EX/MEM is frozen has not really issued yet.
  muldiv_sequencer #(
    .MULDIV_LAT(MULDIV_LAT)
  ) u_muldiv (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start(muldiv_start_i),
    .hold (ex_mem_keep_o),
    .busy (muldiv_busy_o),
    .done (muldiv_done_o)
  );

  logic [CNT_WIDTH-1:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      stall_cnt_q <= '0;
    else if (pc_keep_o && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
  end

  assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MULDIV_LAT=4, CNT_WIDTH=4).
module tb_pipeline_stall_controller;

  localparam int LAT = 4;
  localparam int CW  = 4;

  // Control vector order: pc_keep, if_id_keep, if_id_flush, id_ex_keep,
  // id_ex_zero, ex_mem_keep, mem_wb_zero
  localparam logic [6:0] C_IDLE   = 7'b0000000;
  localparam logic [6:0] C_IDST   = 7'b1100100;
  localparam logic [6:0] C_DMEM   = 7'b1101011;
  localparam logic [6:0] C_BRANCH = 7'b0010000;
  localparam logic [6:0] C_IMEM   = 7'b1010000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_stall_req = 1'b0, branch_taken = 1'b0, hilo_use = 1'b0;
  logic muldiv_start = 1'b0, imem_ready = 1'b1, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic pc_keep, if_id_keep, if_id_flush, id_ex_keep, id_ex_zero, ex_mem_keep, mem_wb_zero;
  logic busy, done;
  logic [CW-1:0] stall_cycles;
  logic [6:0] ctrl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MULDIV_LAT(LAT), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_stall_req_i(id_stall_req), .branch_taken_i(branch_taken),
    .hilo_use_i(hilo_use), .muldiv_start_i(muldiv_start),
    .imem_ready_i(imem_ready), .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
    .pc_keep_o(pc_keep), .if_id_keep_o(if_id_keep), .if_id_flush_o(if_id_flush),
    .id_ex_keep_o(id_ex_keep), .id_ex_zero_o(id_ex_zero),
    .ex_mem_keep_o(ex_mem_keep), .mem_wb_zero_o(mem_wb_zero),
    .muldiv_busy_o(busy), .muldiv_done_o(done), .stall_cycles_o(stall_cycles)
  );

  assign ctrl = {pc_keep, if_id_keep, if_id_flush, id_ex_keep, id_ex_zero, ex_mem_keep, mem_wb_zero};

  // Invariants and protocol checks, sampled away from the active edge.
  always @(negedge clk) begin
    total++;
    if ((if_id_keep & if_id_flush) !== 1'b0 || (id_ex_keep & id_ex_zero) !== 1'b0) begin
      bad++;
      $display("FAIL keep_flush_exclusive got ctrl=%b required no keep+flush pair", ctrl);
    end
    total++;
    if ((muldiv_start & busy) !== 1'b0) begin
      bad++;
      $display("FAIL start_while_busy got start=%b busy=%b required not both", muldiv_start, busy);
    end
  end

  task automatic idle_inputs();
    id_stall_req = 1'b0; branch_taken = 1'b0; hilo_use = 1'b0;
    muldiv_start = 1'b0; imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    id_stall_req = 1'b1; imem_ready = 1'b0; dmem_req = 1'b1; muldiv_start = 1'b1;
    next_cycle();
    total++;
    if (ctrl !== C_IDLE || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_forced got ctrl=%b busy=%b done=%b required 0", ctrl, busy, done);
    end
    total++;
    if (stall_cycles !== 4'd0) begin
      bad++;
      $display("FAIL reset_counter got %0d required 0", stall_cycles);
    end
    idle_inputs();
    next_cycle();
    rst = 1'b0; #1;
    total++;
    if (ctrl !== C_IDLE || busy !== 1'b0 || stall_cycles !== 4'd0) begin
      bad++;
      $display("FAIL reset_release got ctrl=%b busy=%b cnt=%0d required 0/0/0", ctrl, busy, stall_cycles);
    end
  endtask

  task automatic test_id_stall();
    do_reset();
    id_stall_req = 1'b1; #1;
    total++;
    if (ctrl !== C_IDST) begin
      bad++;
      $display("FAIL id_stall_ctrl got %b required %b", ctrl, C_IDST);
    end
    next_cycle();
    id_stall_req = 1'b0; #1;
    total++;
    if (ctrl !== C_IDLE || stall_cycles !== 4'd1) begin
      bad++;
      $display("FAIL id_stall_release got ctrl=%b cnt=%0d required %b/1", ctrl, stall_cycles, C_IDLE);
    end
    next_cycle();
    total++;
    if (stall_cycles !== 4'd1) begin
      bad++;
      $display("FAIL id_stall_count_hold got %0d required 1", stall_cycles);
    end
  endtask

  task automatic test_muldiv();
    do_reset();
    muldiv_start = 1'b1; hilo_use = 1'b1; #1;
    total++;
    if (busy !== 1'b0 || ctrl !== C_IDLE) begin
      bad++;
      $display("FAIL muldiv_pre got busy=%b ctrl=%b required 0/%b", busy, ctrl, C_IDLE);
    end
    next_cycle();
    muldiv_start = 1'b0; #1;
    for (int i = 1; i <= LAT; i++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || ctrl !== C_IDST) begin
        bad++;
        $display("FAIL muldiv_busy_c%0d got busy=%b done=%b ctrl=%b required 1/0/%b",
                 i, busy, done, ctrl, C_IDST);
      end
      next_cycle();
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b1 || ctrl !== C_IDLE || stall_cycles !== 4'(LAT)) begin
      bad++;
      $display("FAIL muldiv_done got busy=%b done=%b ctrl=%b cnt=%0d required 0/1/%b/%0d",
               busy, done, ctrl, stall_cycles, C_IDLE, LAT);
    end
    next_cycle();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL muldiv_done_pulse got done=%b busy=%b required 0/0", done, busy);
    end
    hilo_use = 1'b0;
  endtask

  task automatic test_muldiv_hold();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0; muldiv_start = 1'b1; #1;
    total++;
    if (ctrl !== C_DMEM) begin
      bad++;
      $display("FAIL hold_ctrl got %b required %b", ctrl, C_DMEM);
    end
    next_cycle();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_start_blocked got busy=%b required 0", busy);
    end
    // Issue for real, then freeze for the whole busy window.
    dmem_req = 1'b0; #1;
    next_cycle();
    muldiv_start = 1'b0; dmem_req = 1'b1; #1;
    for (int i = 1; i < LAT; i++) next_cycle();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL freeze_busy got busy=%b required 1", busy);
    end
    next_cycle();
    total++;
    if (done !== 1'b1 || ctrl !== C_DMEM) begin
      bad++;
      $display("FAIL freeze_done got done=%b ctrl=%b required 1/%b", done, ctrl, C_DMEM);
    end
    idle_inputs();
  endtask

  task automatic test_dmem_freeze();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1; #1;
    for (int i = 1; i <= 3; i++) begin
      total++;
      if (ctrl !== C_DMEM) begin
        bad++;
        $display("FAIL dmem_freeze_c%0d got %b required %b", i, ctrl, C_DMEM);
      end
      next_cycle();
    end
    dmem_ready = 1'b1; #1;
    total++;
    if (ctrl !== C_BRANCH || stall_cycles !== 4'd3) begin
      bad++;
      $display("FAIL dmem_release got ctrl=%b cnt=%0d required %b/3", ctrl, stall_cycles, C_BRANCH);
    end
    branch_taken = 1'b0; id_stall_req = 1'b1; dmem_ready = 1'b0; #1;
    total++;
    if (ctrl !== C_DMEM) begin
      bad++;
      $display("FAIL dmem_over_id_stall got %b required %b", ctrl, C_DMEM);
    end
    idle_inputs();
  endtask

  task automatic test_imem();
    do_reset();
    imem_ready = 1'b0; branch_taken = 1'b1; #1;
    total++;
    if (ctrl !== C_BRANCH) begin
      bad++;
      $display("FAIL imem_branch got %b required %b", ctrl, C_BRANCH);
    end
    branch_taken = 1'b0; #1;
    total++;
    if (ctrl !== C_IMEM) begin
      bad++;
      $display("FAIL imem_wait got %b required %b", ctrl, C_IMEM);
    end
    id_stall_req = 1'b1; branch_taken = 1'b1; #1;
    total++;
    if (ctrl !== C_IDST) begin
      bad++;
      $display("FAIL id_stall_over_branch got %b required %b", ctrl, C_IDST);
    end
    idle_inputs();
  endtask

  task automatic test_reset_busy();
    logic saw;
    do_reset();
    muldiv_start = 1'b1; hilo_use = 1'b1;
    next_cycle();
    muldiv_start = 1'b0;
    next_cycle();
    rst = 1'b1; #1;
    total++;
    if (busy !== 1'b0 || ctrl !== C_IDLE) begin
      bad++;
      $display("FAIL rst_busy_forced got busy=%b ctrl=%b required 0/%b", busy, ctrl, C_IDLE);
    end
    next_cycle();
    rst = 1'b0; #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || stall_cycles !== 4'd0) begin
      bad++;
      $display("FAIL rst_busy_after got busy=%b done=%b cnt=%0d required 0/0/0", busy, done, stall_cycles);
    end
    saw = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
      next_cycle();
    end
    total++;
    if (saw !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy_no_done got activity=%b required 0", saw);
    end
    hilo_use = 1'b0;
  endtask

  task automatic test_saturation();
    logic [CW-1:0] exp;
    do_reset();
    id_stall_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      exp = (i > 15) ? 4'd15 : 4'(i);
      total++;
      if (stall_cycles !== exp) begin
        bad++;
        $display("FAIL sat_c%0d got %0d required %0d", i, stall_cycles, exp);
      end
    end
    id_stall_req = 1'b0;
    next_cycle();
    total++;
    if (stall_cycles !== 4'd15) begin
      bad++;
      $display("FAIL sat_hold got %0d required 15", stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_id_stall();
    test_muldiv();
    test_muldiv_hold();
    test_dmem_freeze();
    test_imem();
    test_reset_busy();
    test_saturation();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
